// File: rtl/rptr_empty.sv
// Read-side pointer, Gray pointer and empty/underflow flags for a dual-clock FIFO.
// Optional fill level and almost-empty outputs when RPTR_LEVEL_EN is defined.
module rptr_empty #(
  parameter int ASIZE     = 4,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   wptr_sync,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             runderflow
`ifdef RPTR_LEVEL_EN
  ,
  output logic [ASIZE:0]   rlevel,
  output logic             ralmost_empty
`endif
);

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] rgray_next;
  logic           rd_ok;

  assign rd_ok      = rinc & ~rempty;
  assign rbin_next  = rbin + {{ASIZE{1'b0}}, rd_ok};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin[ASIZE-1:0];

  // Comparing the next pointer lets empty rise on the edge of the last read.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbin_next;
      rptr       <= rgray_next;
      rempty     <= (rgray_next == wptr_sync);
      runderflow <= rinc & rempty;
    end
  end

`ifdef RPTR_LEVEL_EN
  localparam logic [ASIZE:0] AE_LIM = (ASIZE+1)'(AE_THRESH);

  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] diff;

  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      wbin_s[i] = ^(wptr_sync >> i);
    end
  end

  assign diff = wbin_s - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= diff;
      ralmost_empty <= (diff <= AE_LIM);
    end
  end
`endif

endmodule
